// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for fetch and MEM-stage requests.
// Ports: iREN/iaddr -> ihit/iload, dREN/dWEN/daddr/dstore -> dhit/dload,
//        ram* to the RAM, ramload/ram_ready from it, err sticky timeout.
module mem_arbiter #(
  parameter int          TIMEOUT = 64,
  parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    IBUS,
    DBUS,
    RESP
  } state_t;

  state_t state, nextState;

  logic          lastGrantD;
  logic          grantD;
  logic          opWrite;
  logic          errQ;
  logic [31:0]   addrQ;
  logic [31:0]   storeQ;
  logic [31:0]   loadQ;
  logic [CW-1:0] cnt;

  logic dReq;
  logic pickD;
  logic inBus;
  logic timeOut;

  assign dReq    = dREN | dWEN;
  // Data wins unless it won last time and fetch is waiting.
  assign pickD   = dReq & ~(lastGrantD & iREN);
  assign inBus   = (state == IBUS) | (state == DBUS);
  assign timeOut = (cnt == CW'(TIMEOUT));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (pickD)     nextState = DBUS;
        else if (iREN) nextState = IBUS;
      end
      IBUS, DBUS: begin
        if (ram_ready | timeOut) nextState = RESP;
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lastGrantD <= 1'b0;
      grantD     <= 1'b0;
      opWrite    <= 1'b0;
      errQ       <= 1'b0;
      addrQ      <= '0;
      storeQ     <= '0;
      loadQ      <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pickD | iREN) begin
            grantD     <= pickD;
            lastGrantD <= pickD;
            addrQ      <= pickD ? daddr : iaddr;
            storeQ     <= pickD ? dstore : '0;
            opWrite    <= pickD & dWEN;
            cnt        <= '0;
          end
        end
        IBUS, DBUS: begin
          if (ram_ready) begin
            loadQ <= ramload;
          end else if (timeOut) begin
            loadQ <= ERRWORD;
            errQ  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // RAM side sees only latched values, and only while in a bus state.
  assign ramREN   = inBus & ~opWrite;
  assign ramWEN   = inBus & opWrite;
  assign ramaddr  = inBus ? addrQ : '0;
  assign ramstore = inBus ? storeQ : '0;

  // A withdrawn request simply gets no pulse; the access already happened.
  assign ihit  = (state == RESP) & ~grantD & iREN;
  assign dhit  = (state == RESP) & grantD & dReq;
  assign iload = ihit ? loadQ : '0;
  assign dload = dhit ? loadQ : '0;
  assign err   = errQ;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter.
// Cycle table plus hand sequences for timeout and reset.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;
  logic        err;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.TIMEOUT(64), .ERRWORD(32'hBAD1BAD1)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        rdy;
    logic [31:0] rload;
    logic        eIhit;
    logic [31:0] eIload;
    logic        eDhit;
    logic [31:0] eDload;
    logic        eRen;
    logic        eWen;
    logic [31:0] eAddr;
    logic [31:0] eStore;
  } vec_t;

  vec_t vq[$];

  task automatic row(
    input logic i, input logic [31:0] ia,
    input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] ds,
    input logic r, input logic [31:0] rl,
    input logic eih, input logic [31:0] eil,
    input logic edh, input logic [31:0] edl,
    input logic er, input logic ew,
    input logic [31:0] ea, input logic [31:0] es);
    vec_t v;
    v.iREN = i;  v.iaddr = ia;
    v.dREN = dr; v.dWEN = dw;
    v.daddr = da; v.dstore = ds;
    v.rdy = r; v.rload = rl;
    v.eIhit = eih; v.eIload = eil;
    v.eDhit = edh; v.eDload = edl;
    v.eRen = er; v.eWen = ew;
    v.eAddr = ea; v.eStore = es;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic zero(input string tag);
    chk({tag, " ihit"}, 32'(ihit), 0);
    chk({tag, " dhit"}, 32'(dhit), 0);
    chk({tag, " ramREN"}, 32'(ramREN), 0);
    chk({tag, " ramWEN"}, 32'(ramWEN), 0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idleIn();
    iREN = 0; iaddr = 0; dREN = 0; dWEN = 0;
    daddr = 0; dstore = 0; ram_ready = 0; ramload = 0;
  endtask

  initial begin
    string t;
    RST = 1;
    idleIn();
    #3;
    zero("reset");
    chk("reset iload", iload, 0);
    chk("reset dload", dload, 0);
    chk("reset ramaddr", ramaddr, 0);
    chk("reset err", 32'(err), 0);
    tick();
    RST = 0;

    // lone fetch
    row(1,'h40,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
    row(1,'h40,0,0,0,0,1,'h8C220004, 0,0,0,0,1,0,'h40,0);
    row(1,'h40,0,0,0,0,0,0, 1,'h8C220004,0,0,0,0,0,0);
    row(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
    // simultaneous: D, I, D
    row(1,'h80,1,0,'h200,0,0,0, 0,0,0,0,0,0,0,0);
    row(1,'h80,1,0,'h200,0,1,'h11111111, 0,0,0,0,1,0,'h200,0);
    row(1,'h80,1,0,'h200,0,0,0, 0,0,1,'h11111111,0,0,0,0);
    row(1,'h80,1,0,'h200,0,0,0, 0,0,0,0,0,0,0,0);
    row(1,'h80,1,0,'h200,0,1,'h22222222, 0,0,0,0,1,0,'h80,0);
    row(1,'h80,1,0,'h200,0,0,0, 1,'h22222222,0,0,0,0,0,0);
    row(1,'h80,1,0,'h200,0,0,0, 0,0,0,0,0,0,0,0);
    row(1,'h80,1,0,'h200,0,1,'h33333333, 0,0,0,0,1,0,'h200,0);
    row(1,'h80,1,0,'h200,0,0,0, 0,0,1,'h33333333,0,0,0,0);
    row(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
    // ready two cycles late
    row(0,0,1,0,'h300,0,0,0, 0,0,0,0,0,0,0,0);
    row(0,0,1,0,'h300,0,0,0, 0,0,0,0,1,0,'h300,0);
    row(0,0,1,0,'h300,0,0,0, 0,0,0,0,1,0,'h300,0);
    row(0,0,1,0,'h300,0,1,'h44444444, 0,0,0,0,1,0,'h300,0);
    row(0,0,1,0,'h300,0,0,0, 0,0,1,'h44444444,0,0,0,0);
    row(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
    // store latching
    row(0,0,0,1,'h100,'hDEADBEEF,0,0, 0,0,0,0,0,0,0,0);
    row(0,0,0,1,'h999,'h12345678,0,0, 0,0,0,0,0,1,'h100,'hDEADBEEF);
    row(0,0,0,1,'h999,'h12345678,1,0, 0,0,0,0,0,1,'h100,'hDEADBEEF);
    row(0,0,0,1,'h999,'h12345678,0,0, 0,0,1,0,0,0,0,0);
    row(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
    // read+write together is a write
    row(0,0,1,1,'h104,'hCAFEF00D,0,0, 0,0,0,0,0,0,0,0);
    row(0,0,1,1,'h104,'hCAFEF00D,1,0, 0,0,0,0,0,1,'h104,'hCAFEF00D);
    row(0,0,1,1,'h104,'hCAFEF00D,0,0, 0,0,1,0,0,0,0,0);
    row(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
    // withdrawn fetch, pending data served next
    row(1,'h44,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
    row(0,0,1,0,'h208,0,1,'h55555555, 0,0,0,0,1,0,'h44,0);
    row(0,0,1,0,'h208,0,0,0, 0,0,0,0,0,0,0,0);
    row(0,0,1,0,'h208,0,0,0, 0,0,0,0,0,0,0,0);
    row(0,0,1,0,'h208,0,1,'h66666666, 0,0,0,0,1,0,'h208,0);
    row(0,0,1,0,'h208,0,0,0, 0,0,1,'h66666666,0,0,0,0);
    // stray ready in IDLE
    row(0,0,0,0,0,0,1,'h77777777, 0,0,0,0,0,0,0,0);
    row(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);

    foreach (vq[k]) begin
      iREN = vq[k].iREN; iaddr = vq[k].iaddr;
      dREN = vq[k].dREN; dWEN = vq[k].dWEN;
      daddr = vq[k].daddr; dstore = vq[k].dstore;
      ram_ready = vq[k].rdy; ramload = vq[k].rload;
      #2;
      t = $sformatf("row%0d", k);
      chk({t, " ihit"}, 32'(ihit), 32'(vq[k].eIhit));
      chk({t, " iload"}, iload, vq[k].eIload);
      chk({t, " dhit"}, 32'(dhit), 32'(vq[k].eDhit));
      chk({t, " dload"}, dload, vq[k].eDload);
      chk({t, " ramREN"}, 32'(ramREN), 32'(vq[k].eRen));
      chk({t, " ramWEN"}, 32'(ramWEN), 32'(vq[k].eWen));
      chk({t, " ramaddr"}, ramaddr, vq[k].eAddr);
      chk({t, " ramstore"}, ramstore, vq[k].eStore);
      chk({t, " err"}, 32'(err), 0);
      tick();
    end

    // timeout: 65 bus cycles, response on the 66th
    idleIn();
    dREN = 1; daddr = 'h300;
    for (int i = 0; i < 65; i++) begin
      tick();
      chk($sformatf("to bus%0d ramREN", i), 32'(ramREN), 1);
      chk($sformatf("to bus%0d dhit", i), 32'(dhit), 0);
    end
    chk("to err early", 32'(err), 0);
    tick();
    chk("to dhit", 32'(dhit), 1);
    chk("to dload", dload, 32'hBAD1BAD1);
    chk("to err", 32'(err), 1);
    chk("to ramREN", 32'(ramREN), 0);
    dREN = 0;
    tick();
    // err sticks through a good access
    iREN = 1; iaddr = 'h60;
    tick();
    chk("post ramaddr", ramaddr, 'h60);
    ram_ready = 1; ramload = 'h0000ABCD;
    tick();
    ram_ready = 0;
    #1;
    chk("post ihit", 32'(ihit), 1);
    chk("post iload", iload, 'h0000ABCD);
    chk("post err", 32'(err), 1);
    iREN = 0;
    tick();

    // reset during DBUS
    dREN = 1; daddr = 'h500;
    tick();
    chk("rst pre ramREN", 32'(ramREN), 1);
    #2;
    RST = 1;
    #1;
    chk("rst async ramREN", 32'(ramREN), 0);
    chk("rst async ramaddr", ramaddr, 0);
    chk("rst err clr", 32'(err), 0);
    ram_ready = 1; ramload = 'h99999999;
    tick();
    zero("rst hold");
    ram_ready = 0;
    RST = 0;
    iREN = 1; iaddr = 'h70;
    #1;
    zero("rst idle");
    tick();
    chk("rst regrant ramREN", 32'(ramREN), 1);
    chk("rst regrant ramaddr", ramaddr, 'h500);
    ram_ready = 1; ramload = 'h12121212;
    tick();
    ram_ready = 0;
    #1;
    chk("rst regrant dhit", 32'(dhit), 1);
    chk("rst regrant dload", dload, 'h12121212);
    chk("rst regrant ihit", 32'(ihit), 0);
    idleIn();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
